// File: rtl/riscv_run_monitor.sv
// riscv_run_monitor: supervises one processor test run. It counts RUN cycles and
// detects halt (stalled PC or a jal-to-self). It decodes pass/fail from a store to
// the tohost address and enforces a timeout. Every other data-memory store is
// buffered in a first-word-fall-through trace FIFO that is drained with tr_rd_i.
// rset_i is asynchronous and active-low.
module riscv_run_monitor #(
  parameter int unsigned          XLEN        = 32,
  parameter int unsigned          PC_W        = 32,
  parameter int unsigned          MADDR_W     = 8,
  parameter int unsigned          FIFO_DEPTH  = 16,
  parameter int unsigned          HALT_CNT    = 4,
  parameter int unsigned          TIMEOUT     = 100000,
  parameter logic [MADDR_W-1:0]   TOHOST_ADDR = 8'hFC,
  localparam int unsigned         AW          = $clog2(FIFO_DEPTH)
) (
  input  logic               clk_i,
  input  logic               rset_i,      // active-low, asynchronous
  input  logic               start_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [31:0]        ins_i,
  input  logic               dm_we_i,
  input  logic [MADDR_W-1:0] mem_addr_i,
  input  logic [XLEN-1:0]    mem_wdata_i,
  input  logic               tr_rd_i,
  output logic               tr_valid_o,
  output logic [MADDR_W-1:0] tr_addr_o,
  output logic [XLEN-1:0]    tr_data_o,
  output logic [AW:0]        tr_cnt_o,
  output logic               tr_ovf_o,
  output logic [31:0]        cycles_o,
  output logic [2:0]         state_o,
  output logic               done_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_HALT = 3'd2,
    ST_PASS = 3'd3,
    ST_FAIL = 3'd4,
    ST_TOUT = 3'd5
  } state_t;

  localparam int unsigned SW       = $clog2(HALT_CNT + 1);
  localparam logic [31:0] JAL_SELF = 32'h0000_006F;

  state_t              state_q, state_d;
  logic [31:0]         cycles_q, cycles_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [SW-1:0]       stall_q, stall_d;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic [MADDR_W-1:0]  fifo_addr_q [FIFO_DEPTH];
  logic [XLEN-1:0]     fifo_data_q [FIFO_DEPTH];

  logic                push;
  logic                push_ok;
  logic                pop;
  logic                full;
  logic                tohost;
  logic                halt;
  logic                tout;

  // Next-state: run control, halt/timeout/tohost decode and FIFO bookkeeping.
  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    pc_d     = pc_q;
    stall_d  = stall_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    push     = 1'b0;
    push_ok  = 1'b0;
    tohost   = 1'b0;
    halt     = 1'b0;
    tout     = 1'b0;
    full     = (cnt_q == (AW + 1)'(FIFO_DEPTH));
    pop      = tr_rd_i && (cnt_q != '0);

    if (start_i) begin
      // A start pulse restarts the run from a clean slate, whatever the state.
      state_d  = ST_RUN;
      cycles_d = '0;
      pc_d     = pc_i;
      stall_d  = '0;
      wr_d     = '0;
      rd_d     = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (state_q == ST_RUN) begin
        // Saturate rather than wrap; the timeout normally ends the run first.
        cycles_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
        pc_d     = pc_i;
        stall_d  = (pc_i == pc_q) ? stall_q + SW'(1) : '0;

        tohost = dm_we_i && (mem_addr_i == TOHOST_ADDR);
        halt   = ((pc_i == pc_q) && (stall_q == SW'(HALT_CNT - 1))) ||
                 (ins_i == JAL_SELF);
        tout   = (cycles_q == 32'(TIMEOUT - 1));

        // Exit priority: tohost store, then halt, then timeout.
        if (tohost)
          state_d = (mem_wdata_i == XLEN'(1)) ? ST_PASS : ST_FAIL;
        else if (halt)
          state_d = ST_HALT;
        else if (tout)
          state_d = ST_TOUT;

        push = dm_we_i && !tohost;
      end

      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      push_ok = push && (!full || pop);
      if (push && full && !pop)
        ovf_d = 1'b1;

      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop)     rd_d = rd_q + AW'(1);

      case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
        2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State and control registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rset_i) begin
    if (!rset_i) begin
      state_q  <= ST_IDLE;
      cycles_q <= '0;
      pc_q     <= '0;
      stall_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      pc_q     <= pc_d;
      stall_q  <= stall_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Trace storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      fifo_addr_q[wr_q] <= mem_addr_i;
      fifo_data_q[wr_q] <= mem_wdata_i;
    end
  end

  // Head is shown combinationally (fall-through) and forced to zero when empty.
  always_comb begin
    tr_valid_o = (cnt_q != '0);
    tr_addr_o  = tr_valid_o ? fifo_addr_q[rd_q] : '0;
    tr_data_o  = tr_valid_o ? fifo_data_q[rd_q] : '0;
  end

  assign tr_cnt_o = cnt_q;
  assign tr_ovf_o = ovf_q;
  assign cycles_o = cycles_q;
  assign state_o  = state_q;
  assign done_o   = (state_q == ST_HALT) || (state_q == ST_PASS) ||
                    (state_q == ST_FAIL) || (state_q == ST_TOUT);

endmodule
